// File: rtl/xor_share_if.sv
// xor_share_if: request/response bundle between four requesters and xor_share_arbiter
// Signals:
//   req     [3:0]     level request, bit i = requester i
//   a, b    [4*W-1:0] packed operands, requester i at [i*W +: W]
//   ack     [3:0]     one-hot one-cycle completion pulse
//   y       [W-1:0]   registered XOR result, valid while ack is nonzero
//   busy              arbiter FSM not idle
//   gnt_id  [1:0]     current/last granted requester
//   err_cnt [7:0]     saturating self-check mismatch count
// Modports: master = requester side, slave = arbiter side.
interface xor_share_if #(parameter int W = 4);
  logic [3:0] req;
  logic [4*W-1:0] a, b;
  logic [3:0] ack;
  logic [W-1:0] y;
  logic busy;
  logic [1:0] gnt_id;
  logic [7:0] err_cnt;
  modport master (output req, a, b, input ack, y, busy, gnt_id, err_cnt);
  modport slave (input req, a, b, output ack, y, busy, gnt_id, err_cnt);
endinterface

// File: rtl/xor_share_arbiter.sv
// xor_share_arbiter: round-robin time-sharing of one gate-level XOR unit between four requesters
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    xor_share_if.slave (req/a/b in; ack/y/busy/gnt_id/err_cnt out)
// Optional feature: define XOR_SHARE_SELFCHECK_EN to compare the gate network against
// a behavioural XOR at every CALC edge; otherwise err_cnt is tied to 0.
module xor_share_arbiter #(parameter int W = 4) (
  input logic clk,
  input logic rst_n,
  xor_share_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, gnt_q, gnt_d, win, idx;
  logic [W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, y_q, y_d, gx;
  logic [W-1:0] g_or, g_and, g_nand;
  logic [3:0] ack_q, ack_d, elig;
  logic served_q, served_d, found;
  // Shared unit: y = (a | b) & ~(a & b), built from primitives
  for (genvar i = 0; i < W; i++) begin : g_xor
    or  u_or  (g_or[i], op_a_q[i], op_b_q[i]);
    and u_and (g_and[i], op_a_q[i], op_b_q[i]);
    not u_not (g_nand[i], g_and[i]);
    and u_out (gx[i], g_or[i], g_nand[i]);
  end
  // Last winner is masked for the single IDLE cycle following RESP
  always_comb begin
    elig = bus.req & ~(served_q ? (4'b0001 << gnt_q) : 4'b0000);
    found = 1'b0;
    win = ptr_q;
    idx = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    y_d = y_q;
    ack_d = ack_q;
    served_d = state_q == RESP;
    case (state_q)
      IDLE: if (found) begin
        state_d = CALC;
        gnt_d = win;
        ptr_d = win + 2'd1;
        op_a_d = bus.a[win*W +: W];
        op_b_d = bus.b[win*W +: W];
      end
      CALC: begin
        state_d = RESP;
        y_d = gx;
        ack_d = 4'b0001 << gnt_q;
      end
      RESP: begin
        state_d = IDLE;
        ack_d = 4'b0000;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= 2'd0;
      gnt_q <= 2'd0;
      op_a_q <= '0;
      op_b_q <= '0;
      y_q <= '0;
      ack_q <= 4'b0000;
      served_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      y_q <= y_d;
      ack_q <= ack_d;
      served_q <= served_d;
    end
`ifdef XOR_SHARE_SELFCHECK_EN
  logic [7:0] err_q, err_d;
  always_comb err_d = (state_q == CALC && gx != (op_a_q ^ op_b_q) && err_q != 8'hff) ? err_q + 8'd1 : err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 8'd0;
    else err_q <= err_d;
  assign bus.err_cnt = err_q;
`else
  assign bus.err_cnt = 8'd0;
`endif
  assign bus.ack = ack_q;
  assign bus.y = y_q;
  assign bus.busy = state_q != IDLE;
  assign bus.gnt_id = gnt_q;
endmodule
